// File: rtl/rv32i_types.sv
// Shared RV32I types for the load/store unit: data word, funct3 encodings
// and the LSU controller state.
package rv32i_types;

   typedef logic [31:0] rv32i_word;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } store_funct3_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the byte/half addressed by offset out
// of the captured memory word and sign- or zero-extends it.
module lsu_load_align
   import rv32i_types::*;
(
   input  rv32i_word   mdr,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output rv32i_word   rdata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = mdr[{offset, 3'b000} +: 8];
      half_sel = offset[1] ? mdr[31:16] : mdr[15:0];
      case (funct3)
         LB:      rdata = {{24{byte_sel[7]}}, byte_sel};
         LBU:     rdata = {24'h000000, byte_sel};
         LH:      rdata = {{16{half_sel[15]}}, half_sel};
         LHU:     rdata = {16'h0000, half_sel};
         // LW and, when not trapped, undefined encodings return the full word
         default: rdata = mdr;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// RV32I load/store controller: one outstanding access, word-aligned memory port.
// Optional LSU_MISALIGN_TRAP_EN: misaligned/undefined accesses complete with resp_err.
module lsu_ctrl
   import rv32i_types::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byte_enable,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp
);

   lsu_state_t state, state_next;

   logic        we_p0;
   logic [2:0]  funct3_p0;
   logic [1:0]  offset_p0;
   logic        err_p0;
   rv32i_word   mdr_p0;
   rv32i_word   mem_address_p0;
   rv32i_word   mem_wdata_p0;
   logic [3:0]  mem_be_p0;

   logic        accept;
   logic        trap;
   rv32i_word   st_wdata;
   logic [3:0]  st_be;
   rv32i_word   load_data;

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic misaligned(input logic we, input logic [2:0] f3,
                                       input logic [1:0] off);
      logic bad;
      bad = 1'b0;
      if (we) begin
         case (f3)
            SB:      bad = 1'b0;
            SH:      bad = off[0];
            SW:      bad = |off;
            default: bad = 1'b1;
         endcase
      end else begin
         case (f3)
            LB, LBU: bad = 1'b0;
            LH, LHU: bad = off[0];
            LW:      bad = |off;
            default: bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

   assign trap = misaligned(req_we, req_funct3, req_addr[1:0]);
`else
   assign trap = 1'b0;
`endif

   assign accept = req_valid && (state == IDLE);

   // Store lane steering; anything that is not SB/SH goes out as a full word
   always_comb begin
      st_wdata = req_wdata;
      st_be    = 4'b1111;
      if (req_we) begin
         case (req_funct3)
            SB: begin
               st_be    = 4'b0001 << req_addr[1:0];
               st_wdata = req_wdata << {req_addr[1:0], 3'b000};
            end
            SH: begin
               st_be    = 4'b0011 << {req_addr[1], 1'b0};
               st_wdata = req_wdata << {req_addr[1], 4'b0000};
            end
            default: ;
         endcase
      end
   end

   // Stage 0: request latched at accept, memory word latched at mem_resp
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         we_p0          <= 1'b0;
         funct3_p0      <= 3'b000;
         offset_p0      <= 2'b00;
         err_p0         <= 1'b0;
         mdr_p0         <= '0;
         mem_address_p0 <= '0;
         mem_wdata_p0   <= '0;
         mem_be_p0      <= 4'b0000;
      end else begin
         state <= state_next;
         if (accept) begin
            we_p0          <= req_we;
            funct3_p0      <= req_funct3;
            offset_p0      <= req_addr[1:0];
            err_p0         <= trap;
            mem_address_p0 <= trap ? '0 : {req_addr[31:2], 2'b00};
            mem_wdata_p0   <= (req_we && !trap) ? st_wdata : '0;
            mem_be_p0      <= trap ? 4'b0000 : st_be;
         end
         if ((state == READ) && mem_resp) begin
            mdr_p0 <= mem_rdata;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (trap)        state_next = DONE;
               else if (req_we) state_next = WRITE;
               else             state_next = READ;
            end
         end
         READ:    if (mem_resp) state_next = DONE;
         WRITE:   if (mem_resp) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   lsu_load_align u_load_align (
      .mdr    (mdr_p0),
      .offset (offset_p0),
      .funct3 (funct3_p0),
      .rdata  (load_data)
   );

   assign req_ready       = (state == IDLE);
   assign mem_read        = (state == READ);
   assign mem_write       = (state == WRITE);
   assign mem_address     = mem_address_p0;
   assign mem_wdata       = mem_wdata_p0;
   assign mem_byte_enable = mem_be_p0;
   assign resp_valid      = (state == DONE);
   assign resp_rdata      = ((state == DONE) && !we_p0 && !err_p0) ? load_data : '0;

`ifdef LSU_MISALIGN_TRAP_EN
   assign resp_err = (state == DONE) && err_p0;
`else
   assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized accesses
// against a behavioural model of load/store formatting and timing.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_rdata;
   logic        mem_resp;

   always #5 clk = ~clk;

   lsu_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_we          (req_we),
      .req_funct3      (req_funct3),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_err        (resp_err),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_rdata       (mem_rdata),
      .mem_resp        (mem_resp)
   );

   typedef struct {
      bit          we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          wt;
   } txn_t;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] last_rdata, last_addr, last_wdata;
   logic [3:0]  last_be;
   logic        last_err;
   int          last_rd_cycles;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic bit model_trap(bit we, logic [2:0] f3, logic [1:0] off);
`ifdef LSU_MISALIGN_TRAP_EN
      int o;
      o = int'(off);
      if (f3 == 3'd1 || (!we && f3 == 3'd5)) return (o % 2) != 0;
      if (f3 == 3'd2) return o != 0;
      if (f3 == 3'd0 || (!we && f3 == 3'd4)) return 1'b0;
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] model_load(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
      int unsigned v;
      int          o;
      o = int'(off);
      case (f3)
         3'd0, 3'd4: begin
            v = (w >> (8 * o)) & 32'hFF;
            if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
         end
         3'd1, 3'd5: begin
            v = (w >> (16 * (o / 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
         end
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] model_be(bit we, logic [2:0] f3, logic [1:0] off);
      int o;
      int unsigned b;
      o = int'(off);
      if (!we) return 4'hF;
      case (f3)
         3'd0:    b = 1 << o;
         3'd1:    b = 3 << (2 * (o / 2));
         default: b = 15;
      endcase
      return b[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [1:0] off, logic [31:0] wd);
      int o;
      o = int'(off);
      case (f3)
         3'd0:    return wd << (8 * o);
         3'd1:    return wd << (16 * (o / 2));
         default: return wd;
      endcase
   endfunction

   task automatic drive(input txn_t t);
      req_valid  = 1'b1;
      req_we     = t.we;
      req_funct3 = t.f3;
      req_addr   = t.addr;
      req_wdata  = t.wdata;
   endtask

   // Runs one access from the negedge where it is presented to the IDLE negedge after it.
   task automatic run_txn(input txn_t t, input bit hold, input txn_t nxt);
      bit          trap;
      logic [31:0] exp_rd;
      last_rd_cycles = 0;
      last_addr = '0; last_wdata = '0; last_be = '0; last_err = 1'b0; last_rdata = '0;
      if (!req_valid) drive(t);
      chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
      @(posedge clk); @(negedge clk);
      if (hold) drive(nxt); else req_valid = 1'b0;
      trap = model_trap(t.we, t.f3, t.addr[1:0]);
      if (trap) begin
         mem_resp = 1'($urandom_range(0, 1));
         chk("trap_resp_valid", {31'b0, resp_valid}, 32'd1);
         chk("trap_resp_err", {31'b0, resp_err}, 32'd1);
         chk("trap_rdata", resp_rdata, 32'd0);
         chk("trap_no_mem", {30'b0, mem_read, mem_write}, 32'd0);
         last_err = resp_err; last_rdata = resp_rdata;
      end else begin
         for (int k = 0; k <= t.wt; k++) begin
            chk("mem_read", {31'b0, mem_read}, {31'b0, !t.we});
            chk("mem_write", {31'b0, mem_write}, {31'b0, t.we});
            chk("mem_address", mem_address, {t.addr[31:2], 2'b00});
            chk("mem_byte_enable", {28'b0, mem_byte_enable}, {28'b0, model_be(t.we, t.f3, t.addr[1:0])});
            if (t.we) chk("mem_wdata", mem_wdata, model_wdata(t.f3, t.addr[1:0], t.wdata));
            chk("busy_no_resp", {31'b0, resp_valid}, 32'd0);
            chk("busy_not_ready", {31'b0, req_ready}, 32'd0);
            if (mem_read) last_rd_cycles++;
            if (k == 0) begin
               last_addr = mem_address; last_be = mem_byte_enable; last_wdata = mem_wdata;
            end
            mem_resp  = (k == t.wt);
            mem_rdata = (k == t.wt) ? t.rdata : $urandom;
            @(posedge clk); @(negedge clk);
         end
         mem_resp  = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
         exp_rd = t.we ? 32'd0 : model_load(t.f3, t.addr[1:0], t.rdata);
         chk("done_resp_valid", {31'b0, resp_valid}, 32'd1);
         chk("done_resp_err", {31'b0, resp_err}, 32'd0);
         chk("done_rdata", resp_rdata, exp_rd);
         chk("done_mem_idle", {30'b0, mem_read, mem_write}, 32'd0);
         last_err = resp_err; last_rdata = resp_rdata;
      end
      @(posedge clk); @(negedge clk);
      mem_resp = 1'($urandom_range(0, 1));
      chk("post_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("post_ready", {31'b0, req_ready}, 32'd1);
   endtask

   function automatic txn_t mk(bit we, logic [2:0] f3, logic [31:0] addr,
                               logic [31:0] wd, logic [31:0] rd, int wt);
      txn_t t;
      t.we = we; t.f3 = f3; t.addr = addr; t.wdata = wd; t.rdata = rd; t.wt = wt;
      return t;
   endfunction

   txn_t txns[61];
   txn_t none;

   initial begin
      none = mk(1'b0, 3'd2, 32'h0, 32'h0, 32'h0, 0);
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_resp", {29'b0, resp_valid, resp_err, 1'b0}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_ctl", {30'b0, mem_read, mem_write}, 32'd0);
      chk("rst_mem_address", mem_address, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_be", {28'b0, mem_byte_enable}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // literal cases pinning both the DUT and the model
      run_txn(mk(1'b0, 3'd2, 32'h100, 32'h0, 32'h8899AABB, 2), 1'b0, none);
      chk("lw_rdata", last_rdata, 32'h8899AABB);
      chk("lw_addr", last_addr, 32'h100);
      chk("lw_read_cycles", last_rd_cycles, 32'd3);
      run_txn(mk(1'b0, 3'd0, 32'h203, 32'h0, 32'h80000000, 0), 1'b0, none);
      chk("lb_rdata", last_rdata, 32'hFFFFFF80);
      run_txn(mk(1'b0, 3'd4, 32'h203, 32'h0, 32'h80000000, 0), 1'b0, none);
      chk("lbu_rdata", last_rdata, 32'h00000080);
      run_txn(mk(1'b1, 3'd0, 32'h302, 32'h000000AB, 32'h0, 1), 1'b0, none);
      chk("sb_be", {28'b0, last_be}, 32'h4);
      chk("sb_wdata", last_wdata, 32'h00AB0000);
      chk("sb_rdata_zero", last_rdata, 32'd0);
      run_txn(mk(1'b1, 3'd1, 32'h302, 32'h00001234, 32'h0, 0), 1'b0, none);
      chk("sh_be", {28'b0, last_be}, 32'hC);
      chk("sh_wdata", last_wdata, 32'h12340000);
      run_txn(mk(1'b0, 3'd2, 32'h101, 32'h0, 32'hCAFEF00D, 0), 1'b0, none);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_lw_err", {31'b0, last_err}, 32'd1);
      chk("mis_lw_no_read", last_rd_cycles, 32'd0);
      chk("mis_lw_rdata", last_rdata, 32'd0);
`else
      chk("mis_lw_err", {31'b0, last_err}, 32'd0);
      chk("mis_lw_addr", last_addr, 32'h100);
      chk("mis_lw_rdata", last_rdata, 32'hCAFEF00D);
`endif

      // back-to-back: second request held during the first access
      run_txn(mk(1'b0, 3'd1, 32'h0402, 32'h0, 32'h8001_7FFF, 1),
              1'b1, mk(1'b1, 3'd2, 32'h0500, 32'hDEADBEEF, 32'h0, 2));
      chk("b2b_first_rdata", last_rdata, 32'hFFFF8001);
      run_txn(mk(1'b1, 3'd2, 32'h0500, 32'hDEADBEEF, 32'h0, 2), 1'b0, none);
      chk("b2b_second_wdata", last_wdata, 32'hDEADBEEF);

      // reset in the middle of a store, then a stale mem_resp
      drive(mk(1'b1, 3'd2, 32'h0400, 32'h11223344, 32'h0, 0));
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      chk("mid_mem_write", {31'b0, mem_write}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_mem_write", {31'b0, mem_write}, 32'd0);
      chk("rst_async_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_async_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_resp = 1'b1;
      @(posedge clk); @(negedge clk);
      mem_resp = 1'b0;
      chk("stale_resp_ignored", {31'b0, resp_valid}, 32'd0);
      chk("stale_no_access", {30'b0, mem_read, mem_write}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk("stale_resp_later", {31'b0, resp_valid}, 32'd0);

      // randomized accesses, with random back-to-back holding
      for (int i = 0; i < 61; i++) begin
         txns[i] = mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                      $urandom, $urandom, int'($urandom_range(0, 3)));
      end
      for (int i = 0; i < 60; i++) begin
         bit h;
         h = (i < 59) ? 1'($urandom_range(0, 1)) : 1'b0;
         run_txn(txns[i], h, txns[i + 1]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
